// File: rtl/load_align_unit.sv
// load_align_unit: sequential load-data aligner between the load stage and the
// data memory port. Issues one word-aligned read, or two when the access
// crosses a word boundary, then merges byte lanes (little-endian), sign- or
// zero-extends, and returns the result over a valid/ready handshake.
// Optional feature macro: LOAD_ALIGN_SPLIT_EN (builds the second-read state RD1;
// without it, boundary-crossing accesses are rejected with rsp_err).
module load_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);
    localparam logic [OFS_W+1:0] BYTES_W = (OFS_W+2)'(BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
`ifdef LOAD_ALIGN_SPLIT_EN
        RD1  = 2'd3,
`endif
        RESP = 2'd2
    } state_t;

    // Number of bytes moved by an access of the given size code.
    function automatic logic [OFS_W+1:0] size_bytes(input logic [1:0] size);
        return (OFS_W+2)'(1) << size;
    endfunction

    // True when the access spills past the end of its word.
    function automatic logic crosses(input logic [OFS_W-1:0] ofs, input logic [1:0] size);
        return ({2'b00, ofs} + size_bytes(size)) > BYTES_W;
    endfunction

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [1:0]          size_reg, size_next;
    logic                sign_reg, sign_next;
    logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
    logic                rsp_err_reg, rsp_err_next;
`ifdef LOAD_ALIGN_SPLIT_EN
    logic [DATA_W-1:0]   lo_reg, lo_next;
`endif

    logic [OFS_W-1:0]    ofs_reg;
    logic [ADDR_W-1:0]   aligned_addr;
    logic                illegal_size;

    assign ofs_reg      = addr_reg[OFS_W-1:0];
    assign aligned_addr = {addr_reg[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    assign illegal_size = (DATA_W == 32) && (req_size == 2'd3);

    // ---------------------------------------------------------------- extraction
    logic [2*DATA_W-1:0] ext_merged;
    logic [DATA_W-1:0]   ext_shifted;
    logic [DATA_W-1:0]   ext_data;
    logic [OFS_W+1:0]    ext_n;
    logic                ext_fill;

    // Merge the word pair {hi, lo}; hi is the live read data while in RD1.
    always_comb begin
        ext_merged = {{DATA_W{1'b0}}, mem_rdata};
`ifdef LOAD_ALIGN_SPLIT_EN
        if (state_reg == RD1) begin
            ext_merged = {mem_rdata, lo_reg};
        end
`endif
    end

    assign ext_shifted = DATA_W'(ext_merged >> {ofs_reg, 3'b000});
    assign ext_n       = size_bytes(size_reg);

    // Fill value for bytes above the kept ones: top kept bit when signed.
    always_comb begin
        ext_fill = 1'b0;
        case (size_reg)
            2'd0:    ext_fill = sign_reg & ext_shifted[7];
            2'd1:    ext_fill = sign_reg & ext_shifted[15];
            2'd2:    ext_fill = sign_reg & ext_shifted[31];
            default: ext_fill = sign_reg & ext_shifted[DATA_W-1];
        endcase
    end

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            localparam logic [OFS_W+1:0] LANE = (OFS_W+2)'(gi);
            assign ext_data[gi*8 +: 8] = (LANE < ext_n) ? ext_shifted[gi*8 +: 8] : {8{ext_fill}};
        end
    endgenerate

    // ---------------------------------------------------------------- outputs
    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;

    // Memory request and word address follow the read state.
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = '0;
        case (state_reg)
            RD0: begin
                mem_req  = 1'b1;
                mem_addr = aligned_addr;
            end
`ifdef LOAD_ALIGN_SPLIT_EN
            RD1: begin
                mem_req  = 1'b1;
                mem_addr = aligned_addr + ADDR_W'(BYTES);
            end
`endif
            default: ;
        endcase
    end

    // Next-state and datapath capture decisions.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        size_next     = size_reg;
        sign_next     = sign_reg;
        rsp_data_next = rsp_data_reg;
        rsp_err_next  = rsp_err_reg;
`ifdef LOAD_ALIGN_SPLIT_EN
        lo_next       = lo_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next     = req_addr;
                    size_next     = req_size;
                    sign_next     = req_sign;
                    rsp_data_next = '0;
                    rsp_err_next  = 1'b0;
                    if (illegal_size) begin
                        state_next   = RESP;
                        rsp_err_next = 1'b1;
`ifndef LOAD_ALIGN_SPLIT_EN
                    end else if (crosses(req_addr[OFS_W-1:0], req_size)) begin
                        state_next   = RESP;
                        rsp_err_next = 1'b1;
`endif
                    end else begin
                        state_next = RD0;
                    end
                end
            end
            RD0: begin
                if (mem_rvalid) begin
`ifdef LOAD_ALIGN_SPLIT_EN
                    if (crosses(ofs_reg, size_reg)) begin
                        lo_next    = mem_rdata;
                        state_next = RD1;
                    end else begin
                        rsp_data_next = ext_data;
                        state_next    = RESP;
                    end
`else
                    rsp_data_next = ext_data;
                    state_next    = RESP;
`endif
                end
            end
`ifdef LOAD_ALIGN_SPLIT_EN
            RD1: begin
                if (mem_rvalid) begin
                    rsp_data_next = ext_data;
                    state_next    = RESP;
                end
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            size_reg     <= '0;
            sign_reg     <= 1'b0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
`ifdef LOAD_ALIGN_SPLIT_EN
            lo_reg       <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            size_reg     <= size_next;
            sign_reg     <= sign_next;
            rsp_data_reg <= rsp_data_next;
            rsp_err_reg  <= rsp_err_next;
`ifdef LOAD_ALIGN_SPLIT_EN
            lo_reg       <= lo_next;
`endif
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: randomized and directed loads against a byte-level
// reference model of little-endian memory. Works in both builds
// (LOAD_ALIGN_SPLIT_EN defined or not).
module tb_load_align_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
`ifdef LOAD_ALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_sign;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_img [logic [31:0]];

    load_align_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word stored at a word-aligned address: explicit image or a fixed hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    // Reference: gather N bytes one at a time from byte-addressed memory.
    function automatic void ref_load(input logic [31:0] addr, input logic [1:0] size,
                                     input logic sgn, output logic [31:0] data,
                                     output logic err, output int nreads);
        int          n;
        int          ofs;
        logic [63:0] v;
        logic [31:0] a;
        logic [31:0] w;
        logic [7:0]  b;
        n      = 1 << size;
        ofs    = int'(addr[1:0]);
        v      = 64'd0;
        data   = 32'd0;
        err    = 1'b0;
        nreads = 0;
        if (size == 2'd3) begin
            err = 1'b1;
            return;
        end
        if (ofs + n > 4 && !SPLIT) begin
            err = 1'b1;
            return;
        end
        nreads = (ofs + n > 4) ? 2 : 1;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            w = mem_word({a[31:2], 2'b00});
            b = w[8*a[1:0] +: 8];
            v = v | (64'(b) << (8*k));
        end
        if (sgn && n < 4 && ((v >> (8*n - 1)) & 64'd1) == 64'd1)
            v = v | ~((64'd1 << (8*n)) - 64'd1);
        data = v[31:0];
    endfunction

    // One complete load: request, memory responses with mdly wait cycles each,
    // response held for rdly cycles of backpressure.
    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                           input int mdly, input int rdly);
        logic [31:0] exp_data;
        logic        exp_err;
        int          nreads;
        logic [31:0] raddr;
        ref_load(addr, size, sgn, exp_data, exp_err, nreads);
        @(negedge clk);
        check_eq("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_size  = size;
        req_sign  = sgn;
        @(negedge clk);
        // Keep a junk request pending: the unit must not accept it while busy.
        req_addr  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        req_sign  = 1'($urandom_range(0, 1));
        for (int r = 0; r < nreads; r++) begin
            raddr = {addr[31:2], 2'b00} + 32'(4 * r);
            for (int d = 0; d < mdly; d++) begin
                check_eq("mem_req_wait", mem_req, 1'b1);
                check_eq("mem_addr_wait", mem_addr, raddr);
                check_eq("rsp_valid_wait", rsp_valid, 1'b0);
                check_eq("req_ready_busy", req_ready, 1'b0);
                mem_rdata = $urandom;
                @(negedge clk);
            end
            check_eq("mem_req", mem_req, 1'b1);
            check_eq("mem_addr", mem_addr, raddr);
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(raddr);
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        check_eq("rsp_valid", rsp_valid, 1'b1);
        check_eq("mem_req_resp", mem_req, 1'b0);
        check_eq("rsp_data", rsp_data, exp_data);
        check_eq("rsp_err", rsp_err, exp_err);
        check_eq("req_ready_resp", req_ready, 1'b0);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check_eq("rsp_valid_hold", rsp_valid, 1'b1);
            check_eq("rsp_data_hold", rsp_data, exp_data);
            check_eq("rsp_err_hold", rsp_err, exp_err);
            check_eq("req_ready_hold", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_valid_done", rsp_valid, 1'b0);
        check_eq("req_ready_done", req_ready, 1'b1);
        $display("load addr=%08h size=%0d sign=%0d mdly=%0d rdly=%0d -> data=%08h err=%0d (model %08h/%0d)",
                 addr, size, sgn, mdly, rdly, rsp_data, rsp_err, exp_data, exp_err);
    endtask

    task automatic check_reset_outputs(input string phase);
        check_eq({phase, "_req_ready"}, req_ready, 1'b1);
        check_eq({phase, "_mem_req"}, mem_req, 1'b0);
        check_eq({phase, "_mem_addr"}, mem_addr, 32'd0);
        check_eq({phase, "_rsp_valid"}, rsp_valid, 1'b0);
        check_eq({phase, "_rsp_data"}, rsp_data, 32'd0);
        check_eq({phase, "_rsp_err"}, rsp_err, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_size   = '0;
        req_sign   = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        rsp_ready  = 1'b0;

        mem_img[32'h1000] = 32'h80FF_1234;
        mem_img[32'h2000] = 32'hBEEF_0000;
        mem_img[32'h3000] = 32'h4433_2211;
        mem_img[32'h3004] = 32'h8877_6655;
        mem_img[32'h5000] = 32'h1280_FE34;
        mem_img[32'h0000] = 32'hCAFE_F00D;

        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        do_load(32'h0000_1003, 2'd0, 1'b1, 0, 0);   // signed byte -> FFFFFF80
        do_load(32'h0000_2002, 2'd1, 1'b0, 1, 1);   // zero-extended half -> 0000BEEF
        do_load(32'h0000_3002, 2'd2, 1'b0, 0, 0);   // crossing word -> 66554433 or error
        do_load(32'h0000_5001, 2'd1, 1'b1, 3, 4);   // in-word half at ofs 1, wait + backpressure
        do_load(32'h0000_6000, 2'd3, 1'b0, 0, 2);   // illegal size
        do_load(32'hFFFF_FFFE, 2'd2, 1'b1, 1, 0);   // crossing with address wrap
        do_load(32'h0000_1000, 2'd2, 1'b1, 2, 0);   // full word ignores sign

        // Reset mid-transaction, then a stale read completion.
        @(negedge clk);
        req_valid = 1'b1;
        req_sign  = 1'b0;
        req_size  = 2'd2;
`ifdef LOAD_ALIGN_SPLIT_EN
        req_addr  = 32'h0000_3002;
`else
        req_addr  = 32'h0000_1000;
`endif
        @(negedge clk);
        req_valid = 1'b0;
`ifdef LOAD_ALIGN_SPLIT_EN
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(32'h0000_3000);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_eq("pre_rst_mem_addr", mem_addr, 32'h0000_3004);
`else
        check_eq("pre_rst_mem_addr", mem_addr, 32'h0000_1000);
`endif
        check_eq("pre_rst_mem_req", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_eq("stale_rsp_valid", rsp_valid, 1'b0);
        check_eq("stale_mem_req", mem_req, 1'b0);
        check_eq("stale_req_ready", req_ready, 1'b1);
        do_load(32'h0000_0000, 2'd2, 1'b0, 0, 0);
        do_load(32'h0000_0001, 2'd0, 1'b1, 1, 1);

        // Randomized loads.
        for (int t = 0; t < 60; t++) begin
            do_load($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Sequential load-data aligner between the core's load stage and the data memory port; successor to the single-cycle combinational extractor.
- Accepts one load request at a time (address, size, signedness) and issues one or two word-aligned memory reads.
- Selects and merges byte lanes (little-endian: byte 0 in bits 7:0), then sign- or zero-extends and returns the result through a valid/ready handshake.
- Generalised to a parametrised data width; adds misaligned accesses that cross a word boundary.

Parameters:
- DATA_W, 32, memory/register data width in bits; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- BYTES, DATA_W/8, derived (localparam): bytes per word.
- OFS_W, log2(BYTES), derived (localparam): width of the in-word byte offset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (3 is legal only when DATA_W=64).
- req_sign  in  1  1 = sign-extend, 0 = zero-extend.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  word-aligned read address (low OFS_W bits are 0).
- mem_rvalid  in  1  memory read completes this cycle.
- mem_rdata  in  DATA_W  read data; valid when mem_rvalid=1.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  DATA_W  extracted and extended load data.
- rsp_err  out  1  request rejected (illegal size, or misaligned with the split feature disabled).

Behaviour:
- Reset (asynchronous, any state): state=IDLE; req_ready=1; mem_req=0; mem_addr=0; rsp_valid=0; rsp_data=0; rsp_err=0.
  - Reset asserted mid-transaction abandons the transaction. A later mem_rvalid for an abandoned read is ignored, because it only has effect in RD0/RD1.
- States: IDLE, RD0, RD1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr, size, sign; compute N = 1<<size and ofs = addr[OFS_W-1:0].
  - Illegal size (size=3 with DATA_W=32): go to RESP with rsp_err=1, rsp_data=0.
  - Otherwise go to RD0.
- RD0:
  - mem_req=1, mem_addr = addr with low OFS_W bits cleared; both held stable until mem_rvalid.
  - On mem_rvalid: store lo=mem_rdata.
  - cross = (ofs + N > BYTES). If cross, go to RD1; else go to RESP.
  - mem_rvalid may arrive in the same cycle mem_req first rises, or any number of cycles later.
- RD1:
  - mem_req=1, mem_addr = aligned address + BYTES; the aligned address wraps modulo 2^ADDR_W.
  - On mem_rvalid: store hi=mem_rdata, go to RESP.
- Extraction:
  - Form the 2*DATA_W value {hi, lo}; hi=0 when not crossing.
  - Shift right by ofs*8 and keep the low N bytes.
  - Extend to DATA_W: replicate the top kept bit if sign=1, else fill with 0.
  - A full-width access (N=BYTES) ignores sign.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are registered and stable while rsp_valid=1.
  - On rsp_ready, return to IDLE.
  - req_ready=0 in every state except IDLE, so there is no request overlap.
- Latency from request acceptance to rsp_valid:
  - aligned or in-word access: 1 + (memory cycles) + 1;
  - crossing access: one extra memory round trip;
  - error: exactly 1 cycle.
- mem_req drops in the cycle after mem_rvalid, unless the state moves straight from RD0 to RD1.

Optional Feature:
- LOAD_ALIGN_SPLIT_EN
  - Defined: crossing accesses use RD1 as described above.
  - Undefined: the RD1 state is not built. A crossing access skips the memory read and goes from IDLE to RESP with rsp_err=1, rsp_data=0.
  - Non-crossing unaligned accesses (e.g. a half at ofs=1) work in both builds.

Test Plan:
1. Byte load, sign: DATA_W=32, addr=0x1003, size=0, sign=1, mem returns 0x80FF_1234 → mem_addr=0x1000, single read, rsp_data=0xFFFF_FF80, rsp_err=0.
2. Half load, zero-extend: addr=0x2002, size=1, sign=0, data=0xBEEF_0000 → rsp_data=0x0000_BEEF.
3. Crossing word load with split enabled: addr=0x3002, size=2, reads 0x3000→0x4433_2211 then 0x3004→0x8877_6655 → rsp_data=0x6655_4433. Also check that rsp_err=1 with no memory read when LOAD_ALIGN_SPLIT_EN is undefined.
4. Backpressure and wait states: mem_rvalid delayed 3 cycles, rsp_ready held low 4 cycles → rsp_valid and rsp_data stable throughout, req_ready=0 until the handshake completes.
5. Illegal size: DATA_W=32, size=3 → rsp_err=1 one cycle after acceptance, mem_req never asserted.
6. Reset mid-transaction: rst_n low while in RD1 → all outputs return to reset values immediately. A later stale mem_rvalid is ignored, and the next request at addr=0x0 completes correctly.
